// File: rtl/alu_sched_pkg.sv
// Shared definitions for the ALU scheduler: ALU op codes, FSM state encoding,
// default parameters and the op-to-ALU-control mapping.
package alu_sched_pkg;

  localparam int unsigned WIDTH_DEF      = 32;
  localparam int unsigned MUL_CYCLES_DEF = 2;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_XOR  = 3'b001;
  localparam logic [2:0] OP_SLL  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_SRAI = 3'b110;
  localparam logic [2:0] OP_ILL  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MULW = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Illegal ops still drive a harmless control code onto the ALU.
  function automatic logic [2:0] alu_ctrl_for(input logic [2:0] op);
    return (op == OP_ILL) ? OP_ADD : op;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way request arbiter with its last_grant history register.
// Ports: clk, rst_n (sync, active-low), en (arbitration window), valid0/valid1
// (requests), grant0/grant1 (one-hot grant, combinational).
// Build option: ALU_SCHED_FIXED_PRIO_EN makes requester 0 always win a tie.
module rr_arbiter2 (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic valid0,
  input  logic valid1,
  output logic grant0,
  output logic grant1
);

`ifdef ALU_SCHED_FIXED_PRIO_EN

  // Requester 0 has absolute priority; no history is kept.
  assign grant0 = en & valid0;
  assign grant1 = en & valid1 & ~valid0;

`else

  logic last_grant;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (en) begin
      if (valid0 && valid1) begin
        grant0 = last_grant;
        grant1 = ~last_grant;
      end else begin
        grant0 = valid0;
        grant1 = valid1;
      end
    end
  end

  // History moves only when a grant is actually taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (grant0) begin
      last_grant <= 1'b0;
    end else if (grant1) begin
      last_grant <= 1'b1;
    end
  end

`endif

endmodule

// File: rtl/alu_scheduler.sv
// Shares one combinational ALU between the EX stage (req0) and an auxiliary
// unit (req1). Arbitrates, registers operands onto the ALU, holds MUL for
// MUL_CYCLES cycles and returns a tagged result over a valid/ready channel.
// Ports: clk_i, rst_i (sync, active-low); reqN_valid_i/ready_o/op_i/data1_i/
// data2_i (N=0,1); resp_valid_o/ready_i/id_o/data_o/err_o; alu_data1_o,
// alu_data2_o, alu_ctrl_o to the ALU, alu_data_i from it; busy_o.
// Build option: ALU_SCHED_FIXED_PRIO_EN (handled in rr_arbiter2).
module alu_scheduler
  import alu_sched_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [2:0]       req0_op_i,
  input  logic [WIDTH-1:0] req0_data1_i,
  input  logic [WIDTH-1:0] req0_data2_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [2:0]       req1_op_i,
  input  logic [WIDTH-1:0] req1_data1_i,
  input  logic [WIDTH-1:0] req1_data2_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic             resp_id_o,
  output logic [WIDTH-1:0] resp_data_o,
  output logic             resp_err_o,
  output logic [WIDTH-1:0] alu_data1_o,
  output logic [WIDTH-1:0] alu_data2_o,
  output logic [2:0]       alu_ctrl_o,
  input  logic [WIDTH-1:0] alu_data_i,
  output logic             busy_o
);

  // Counter only needs to hold MUL_CYCLES-2.
  localparam int unsigned CNT_W     = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES - 1) : 1;
  localparam bit          MUL_MULTI = (MUL_CYCLES > 1);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic             mul_q;
  logic             err_q;
  logic             grant0;
  logic             grant1;
  logic             arb_en;
  logic             load;
  logic             capture;
  logic             release_resp;
  logic             mul_wait;
  logic [2:0]       op_sel;

  // Grants are only offered in IDLE and never while reset is asserted.
  assign arb_en   = (state == ST_IDLE) && rst_i;
  assign mul_wait = mul_q && MUL_MULTI;
  assign op_sel   = grant1 ? req1_op_i : req0_op_i;

  rr_arbiter2 u_arb (
    .clk    (clk_i),
    .rst_n  (rst_i),
    .en     (arb_en),
    .valid0 (req0_valid_i),
    .valid1 (req1_valid_i),
    .grant0 (grant0),
    .grant1 (grant1)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE: if (grant0 || grant1) next_state = ST_EXEC;
      ST_EXEC: next_state = mul_wait ? ST_MULW : ST_RESP;
      ST_MULW: if (cnt == '0) next_state = ST_RESP;
      ST_RESP: if (resp_ready_i) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Handshake outputs and datapath strobes.
  always_comb begin
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    load         = 1'b0;
    capture      = 1'b0;
    release_resp = 1'b0;
    unique case (state)
      ST_IDLE: begin
        req0_ready_o = grant0;
        req1_ready_o = grant1;
        load         = grant0 | grant1;
      end
      ST_EXEC: capture      = ~mul_wait;
      ST_MULW: capture      = (cnt == '0);
      ST_RESP: release_resp = resp_ready_i;
      default: ;
    endcase
  end

  // Operand, counter and response registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      alu_data1_o  <= '0;
      alu_data2_o  <= '0;
      alu_ctrl_o   <= '0;
      mul_q        <= 1'b0;
      err_q        <= 1'b0;
      cnt          <= '0;
      resp_id_o    <= 1'b0;
      resp_data_o  <= '0;
      resp_err_o   <= 1'b0;
      resp_valid_o <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      if (load) begin
        alu_data1_o <= grant1 ? req1_data1_i : req0_data1_i;
        alu_data2_o <= grant1 ? req1_data2_i : req0_data2_i;
        alu_ctrl_o  <= alu_ctrl_for(op_sel);
        mul_q       <= (op_sel == OP_MUL);
        err_q       <= (op_sel == OP_ILL);
        resp_id_o   <= grant1;
      end

      // Load remaining MUL hold cycles on leaving EXEC, then count down.
      if (state == ST_EXEC && mul_wait) begin
        cnt <= CNT_W'(MUL_CYCLES - 2);
      end else if (state == ST_MULW && cnt != '0) begin
        cnt <= cnt - CNT_W'(1);
      end

      if (capture) begin
        resp_data_o <= err_q ? '0 : alu_data_i;
        resp_err_o  <= err_q;
      end else if (release_resp) begin
        resp_data_o <= '0;
        resp_err_o  <= 1'b0;
      end

      resp_valid_o <= (next_state == ST_RESP);
      busy_o       <= (next_state != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// Self-checking bench for alu_scheduler (MUL_CYCLES=3) with a behavioural ALU
// and a scoreboard of expected responses.
module tb_alu_scheduler;
  import alu_sched_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned MC = 3;

  logic         clk;
  logic         rst_i;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]   req0_op, req1_op;
  logic [W-1:0] req0_d1, req0_d2, req1_d1, req1_d2;
  logic         resp_valid, resp_ready, resp_id, resp_err;
  logic [W-1:0] resp_data;
  logic [W-1:0] alu_d1, alu_d2, alu_res;
  logic [2:0]   alu_ctrl;
  logic         busy;

  alu_scheduler #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req0_valid_i (req0_valid),
    .req0_ready_o (req0_ready),
    .req0_op_i    (req0_op),
    .req0_data1_i (req0_d1),
    .req0_data2_i (req0_d2),
    .req1_valid_i (req1_valid),
    .req1_ready_o (req1_ready),
    .req1_op_i    (req1_op),
    .req1_data1_i (req1_d1),
    .req1_data2_i (req1_d2),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_id_o    (resp_id),
    .resp_data_o  (resp_data),
    .resp_err_o   (resp_err),
    .alu_data1_o  (alu_d1),
    .alu_data2_o  (alu_d2),
    .alu_ctrl_o   (alu_ctrl),
    .alu_data_i   (alu_res),
    .busy_o       (busy)
  );

  // Behavioural ALU attached to the scheduler.
  always_comb begin
    alu_res = 32'hDEAD_BEEF;
    case (alu_ctrl)
      OP_AND:  alu_res = alu_d1 & alu_d2;
      OP_XOR:  alu_res = alu_d1 ^ alu_d2;
      OP_SLL:  alu_res = alu_d1 << alu_d2[4:0];
      OP_ADD:  alu_res = alu_d1 + alu_d2;
      OP_SUB:  alu_res = alu_d1 - alu_d2;
      OP_MUL:  alu_res = alu_d1 * alu_d2;
      OP_SRAI: alu_res = $signed(alu_d1) >>> alu_d2[4:0];
      default: alu_res = 32'hDEAD_BEEF;
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic        err;
    int          t;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   grants[$];

  // Reference result computed from the request as issued.
  function automatic exp_t mk_exp(input logic id, input logic [2:0] op,
                                  input logic [31:0] a, input logic [31:0] b, input int t);
    exp_t e;
    logic signed [63:0] p;
    logic [63:0] ext;
    e.id = id; e.err = 1'b0; e.t = t; e.lat = 2;
    case (op)
      OP_AND:  e.data = a & b;
      OP_XOR:  e.data = a ^ b;
      OP_SLL:  e.data = a << b[4:0];
      OP_ADD:  e.data = a + b;
      OP_SUB:  e.data = a + (~b) + 32'd1;
      OP_MUL: begin
        p = $signed(a) * $signed(b);
        e.data = p[31:0];
        e.lat  = 1 + MC;
      end
      OP_SRAI: begin
        ext    = {{32{a[31]}}, a} >> b[4:0];
        e.data = ext[31:0];
      end
      default: begin
        e.data = 32'd0;
        e.err  = 1'b1;
      end
    endcase
    return e;
  endfunction

  // Monitor: push on accept, check latency on rise, pop on handshake.
  logic prev_valid = 1'b0;
  initial forever begin
    @(negedge clk);
    if (!rst_i) begin
      sb.delete();
      prev_valid = 1'b0;
    end else begin
      if (req0_valid && req0_ready) sb.push_back(mk_exp(1'b0, req0_op, req0_d1, req0_d2, cyc));
      if (req1_valid && req1_ready) sb.push_back(mk_exp(1'b1, req1_op, req1_d1, req1_d2, cyc));
      if (resp_valid && !prev_valid && sb.size() > 0)
        check("latency", 32'(cyc - sb[0].t), 32'(sb[0].lat));
      if (resp_valid && resp_ready) begin
        check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check("resp_data", resp_data, e.data);
          check("resp_id",   32'(resp_id), 32'(e.id));
          check("resp_err",  32'(resp_err), 32'(e.err));
        end
      end
      prev_valid = resp_valid;
    end
  end

  task automatic set_req(input int port, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (port == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_d1 = a; req0_d2 = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_d1 = a; req1_d2 = b;
    end
  endtask

  task automatic set_rand(input int port);
    set_req(port, 3'($urandom_range(0, 6)), $urandom, $urandom);
  endtask

  // Single request: wait for acceptance, then check the ALU port registers.
  task automatic issue(input int port, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int   waited = 0;
    logic acc    = 1'b0;
    @(posedge clk); #1;
    set_req(port, op, a, b);
    while (!acc && waited < 100) begin
      @(negedge clk);
      waited++;
      acc = (port == 0) ? (req0_valid & req0_ready) : (req1_valid & req1_ready);
    end
    check($sformatf("accept_p%0d", port), 32'(acc), 32'd1);
    @(posedge clk); #1;
    if (port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    if (acc) begin
      @(negedge clk);
      check("alu_ctrl",  32'(alu_ctrl), 32'(alu_ctrl_for(op)));
      check("alu_data1", alu_d1, a);
      check("alu_data2", alu_d2, b);
    end
  endtask

  // Both requesters held valid until n grants; grant order recorded.
  task automatic dual(input int n);
    int got    = 0;
    int budget = 0;
    @(posedge clk); #1;
    if (!req0_valid) set_rand(0);
    if (!req1_valid) set_rand(1);
    while (got < n && budget < 300) begin
      @(negedge clk);
      budget++;
      if (req0_valid && req0_ready) begin
        grants.push_back(0); got++;
        @(posedge clk); #1;
        if (got < n) set_rand(0);
      end else if (req1_valid && req1_ready) begin
        grants.push_back(1); got++;
        @(posedge clk); #1;
        if (got < n) set_rand(1);
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("dual_accepts", 32'(got), 32'(n));
  endtask

  task automatic drain();
    int w = 0;
    while ((sb.size() != 0 || busy || resp_valid) && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("drain_sb_empty", 32'(sb.size()), 32'd0);
    check("drain_idle", 32'(busy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_data"},  resp_data, 32'd0);
    check({tag, "_id"},    32'(resp_id), 32'd0);
    check({tag, "_err"},   32'(resp_err), 32'd0);
    check({tag, "_alu1"},  alu_d1, 32'd0);
    check({tag, "_alu2"},  alu_d2, 32'd0);
    check({tag, "_ctrl"},  32'(alu_ctrl), 32'd0);
  endtask

  initial begin
    logic [31:0] held_data;
    rst_i = 1'b0; resp_ready = 1'b1;
    req0_valid = 1'b0; req0_op = '0; req0_d1 = '0; req0_d2 = '0;
    req1_valid = 1'b0; req1_op = '0; req1_d1 = '0; req1_d2 = '0;

    // Reset state, including readiness while requests are pending in reset.
    repeat (3) @(posedge clk);
    #1; req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    check_all_zero("reset");
    check("reset_ready0", 32'(req0_ready), 32'd0);
    check("reset_ready1", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; rst_i = 1'b1;

    // 1: ADD 5,7 from req0.
    issue(0, OP_ADD, 32'd5, 32'd7);
    drain();

    // 2: MUL 6,-3 from req1.
    issue(1, OP_MUL, 32'd6, 32'hFFFF_FFFD);
    drain();

    // 3: contention for four transactions.
    grants.delete();
    dual(4);
    drain();
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_SCHED_FIXED_PRIO_EN
      check($sformatf("grant_%0d", i), 32'(grants.size() > i ? grants[i] : -1), 32'd0);
`else
      check($sformatf("grant_%0d", i), 32'(grants.size() > i ? grants[i] : -1), 32'(i % 2));
`endif
    end

    // 4: illegal op, then arithmetic shift of a negative value.
    issue(0, OP_ILL, 32'd123, 32'd456);
    drain();
    issue(0, OP_SRAI, 32'h8000_0000, 32'd4);
    drain();

    // 5: consumer stalls; response must stay put and no grants occur.
    resp_ready = 1'b0;
    issue(0, OP_ADD, 32'd100, 32'd23);
    for (int w = 0; w < 20 && !resp_valid; w++) @(negedge clk);
    check("stall_valid_seen", 32'(resp_valid), 32'd1);
    @(posedge clk); #1;
    set_rand(0);
    set_rand(1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_valid",  32'(resp_valid), 32'd1);
      check("stall_data",   resp_data, 32'd123);
      check("stall_id",     32'(resp_id), 32'd0);
      check("stall_ready0", 32'(req0_ready), 32'd0);
      check("stall_ready1", 32'(req1_ready), 32'd0);
      check("stall_busy",   32'(busy), 32'd1);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    dual(2);
    drain();

    // 6: reset while a MUL is waiting, then a fresh XOR.
    issue(1, OP_MUL, 32'd9, 32'd9);
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_all_zero("midreset");
    @(posedge clk); #1;
    rst_i = 1'b1;
    issue(0, OP_XOR, 32'h0000_00F0, 32'h0000_00FF);
    drain();

    // Random single requests across both ports.
    for (int i = 0; i < 8; i++) begin
      issue(int'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom);
      drain();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
